// File: rtl/wb_slave_pkg.sv
// Shared types and constants for the Wishbone classic register-file responder.
package wb_slave_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;
    localparam int IDX_MSB = 5;
    localparam int IDX_LSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [WB_DW-1:0] merge_lanes(
        input logic [WB_DW-1:0]   old_word,
        input logic [WB_DW-1:0]   new_word,
        input logic [WB_SELW-1:0] sel
    );
        logic [WB_DW-1:0] res;
        res = old_word;
        for (int n = 0; n < WB_SELW; n++) begin
            if (sel[n]) begin
                res[8*n +: 8] = new_word[8*n +: 8];
            end else begin
                res[8*n +: 8] = old_word[8*n +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_slave_decode.sv
// Address decoder: 64-byte block hit and word classification (register, status, unmapped).
module wb_slave_decode
    import wb_slave_pkg::*;
#(
    parameter int          NUM_REGS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic [WB_DW-1:0]       adr,
    output logic                   hit,
    output logic [IDX_MSB-IDX_LSB:0] idx,
    output logic                   is_status,
    output logic                   is_unmapped
);

    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    logic [4:0] idx_ext_s;
    logic       unused_lane_bits_s;

    assign hit         = (adr[WB_DW-1:IDX_MSB+1] == BASE_ADDR[WB_DW-1:IDX_MSB+1]);
    assign idx         = adr[IDX_MSB:IDX_LSB];
    // One extra bit so NUM_REGS=16 never aliases the status slot onto index 0.
    assign idx_ext_s   = {1'b0, idx};
    assign is_status   = (idx_ext_s == NUM_REGS_W);
    assign is_unmapped = (idx_ext_s > NUM_REGS_W);

    assign unused_lane_bits_s = ^adr[IDX_LSB-1:0];

endmodule

// File: rtl/wishbone_slave_regfile.sv
// Wishbone B3 classic responder: NUM_REGS R/W words plus one read-only status word.
// Define WB_SLAVE_ERR_EN to answer unmapped, status-write and sel==0 cycles with err_o.
module wishbone_slave_regfile
    import wb_slave_pkg::*;
#(
    parameter int          NUM_REGS    = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [WB_DW-1:0]          adr_i,
    input  logic [WB_DW-1:0]          dat_i,
    output logic [WB_DW-1:0]          dat_o,
    input  logic                      we_i,
    input  logic [WB_SELW-1:0]        sel_i,
    input  logic                      stb_i,
    input  logic                      cyc_i,
    output logic                      ack_o,
    output logic                      err_o,
    output logic [WB_DW*NUM_REGS-1:0] regs_o,
    input  logic [WB_DW-1:0]          status_i
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                         state_r;
    logic [3:0]                     wait_cnt_r;
    logic [NUM_REGS-1:0][WB_DW-1:0] regs_r;
    logic                           ack_r;
    logic                           err_r;
    logic [WB_DW-1:0]               dat_r;

    logic                           hit_s;
    logic [3:0]                     idx_s;
    logic                           is_status_s;
    logic                           is_unmapped_s;
    logic                           req_s;
    logic                           commit_s;
    logic                           reject_s;
    logic [WB_DW-1:0]               rd_data_s;

    wb_slave_decode #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .adr         (adr_i),
        .hit         (hit_s),
        .idx         (idx_s),
        .is_status   (is_status_s),
        .is_unmapped (is_unmapped_s)
    );

    assign req_s  = cyc_i & stb_i;
    assign dat_o  = dat_r;
    assign ack_o  = ack_r;
    assign err_o  = err_r;
    assign regs_o = regs_r;

    // Cycles answered with err_o instead of ack_o.
    always_comb begin
        reject_s = 1'b0;
`ifdef WB_SLAVE_ERR_EN
        if (is_unmapped_s || (is_status_s && we_i) || (sel_i == 4'h0)) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
`endif
    end

    // Commit point: the edge that moves the FSM into ACK.
    always_comb begin
        commit_s = 1'b0;
        case (state_r)
            IDLE:    commit_s = req_s && hit_s && (WAIT_CYCLES == 0);
            WAIT:    commit_s = req_s && (wait_cnt_r == 4'd0);
            ACK:     commit_s = 1'b0;
            default: commit_s = 1'b0;
        endcase
    end

    // Read mux over R/W registers, status word and unmapped slots.
    always_comb begin
        rd_data_s = '0;
        if (is_status_s) begin
            rd_data_s = status_i;
        end else if (is_unmapped_s) begin
            rd_data_s = '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                rd_data_s = rd_data_s | ((idx_s == 4'(k)) ? regs_r[k] : 32'h0000_0000);
            end
        end
    end

    // Bus FSM, wait counter, register bank and registered responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            dat_r      <= '0;
            regs_r     <= '0;
        end else begin
            ack_r <= commit_s && !reject_s;
            err_r <= commit_s && reject_s;

            case (state_r)
                IDLE: begin
                    if (req_s && hit_s) begin
                        if (WAIT_CYCLES > 0) begin
                            state_r    <= WAIT;
                            wait_cnt_r <= WAIT_LOAD;
                        end else begin
                            state_r    <= ACK;
                            wait_cnt_r <= 4'd0;
                        end
                    end else begin
                        state_r    <= IDLE;
                        wait_cnt_r <= 4'd0;
                    end
                end
                WAIT: begin
                    if (!req_s) begin
                        state_r    <= IDLE;
                        wait_cnt_r <= 4'd0;
                    end else if (wait_cnt_r == 4'd0) begin
                        state_r    <= ACK;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ACK: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    wait_cnt_r <= 4'd0;
                end
            endcase

            // Writes to status/unmapped slots match no index and fall through untouched.
            if (commit_s && !reject_s) begin
                if (we_i) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (idx_s == 4'(k)) begin
                            regs_r[k] <= merge_lanes(regs_r[k], dat_i, sel_i);
                        end
                    end
                end else begin
                    dat_r <= rd_data_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_wishbone_slave_regfile.sv
// Directed bench for wishbone_slave_regfile: one instance with no wait states, one with three.
module tb_wishbone_slave_regfile;

    localparam int          NREGS = 4;
    localparam logic [31:0] BASE  = 32'h8000_0040;

    logic         clk;
    logic         rst;
    logic [31:0]  adr      [2];
    logic [31:0]  wdat     [2];
    logic [31:0]  rd_dat   [2];
    logic         bus_we   [2];
    logic [3:0]   sel      [2];
    logic         stb      [2];
    logic         cyc      [2];
    logic         ack      [2];
    logic         err      [2];
    logic [127:0] regs_out [2];
    logic [31:0]  status   [2];

    // Reference model: register contents and the responses expected this cycle.
    logic [31:0]  mreg     [2][NREGS];
    logic         exp_ack  [2];
    logic         exp_err  [2];
    logic [31:0]  exp_dat  [2];

    int checks = 0;
    int errors = 0;

    wishbone_slave_regfile #(.NUM_REGS(NREGS), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr[0]), .dat_i(wdat[0]), .dat_o(rd_dat[0]),
        .we_i(bus_we[0]), .sel_i(sel[0]), .stb_i(stb[0]), .cyc_i(cyc[0]),
        .ack_o(ack[0]), .err_o(err[0]), .regs_o(regs_out[0]), .status_i(status[0])
    );

    wishbone_slave_regfile #(.NUM_REGS(NREGS), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr[1]), .dat_i(wdat[1]), .dat_o(rd_dat[1]),
        .we_i(bus_we[1]), .sel_i(sel[1]), .stb_i(stb[1]), .cyc_i(cyc[1]),
        .ack_o(ack[1]), .err_o(err[1]), .regs_o(regs_out[1]), .status_i(status[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NREGS; k++) mreg[d][k] = 32'h0;
            exp_ack[d] = 1'b0;
            exp_err[d] = 1'b0;
            exp_dat[d] = 32'h0;
        end
    endtask

    // Compare every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("ack%0d", d), 128'(ack[d]), 128'(exp_ack[d]));
            check($sformatf("err%0d", d), 128'(err[d]), 128'(exp_err[d]));
            check($sformatf("dat%0d", d), 128'(rd_dat[d]), 128'(exp_dat[d]));
            check($sformatf("regs%0d", d), regs_out[d],
                  {mreg[d][3], mreg[d][2], mreg[d][1], mreg[d][0]});
        end
    end

    // One master cycle; abort_at >= 0 drops cyc/stb after that many request cycles.
    task automatic xfer(input int d, input logic w_en, input logic [31:0] a,
                        input logic [31:0] dv, input logic [3:0] s,
                        input logic [31:0] st, input int abort_at);
        int lat;
        bit hit;
        int idx;
        bit bad;
        lat = (d == 0) ? 0 : 3;
        hit = (a[31:6] == BASE[31:6]);
        idx = int'((a - BASE) >> 2);
        bad = 1'b0;
`ifdef WB_SLAVE_ERR_EN
        bad = (idx > NREGS) || ((idx == NREGS) && w_en) || (s == 4'h0);
`endif
        @(posedge clk); #1;
        cyc[d] = 1'b1; stb[d] = 1'b1; bus_we[d] = w_en;
        adr[d] = a; wdat[d] = dv; sel[d] = s; status[d] = st;
        if (abort_at >= 0) begin
            repeat (abort_at) begin @(posedge clk); #1; end
            cyc[d] = 1'b0; stb[d] = 1'b0;
            repeat (6) begin @(posedge clk); #1; end
        end else begin
            repeat (lat + 1) begin @(posedge clk); #1; end
            if (hit) begin
                exp_ack[d] = !bad;
                exp_err[d] = bad;
                if (!bad) begin
                    if (w_en) begin
                        if (idx < NREGS) begin
                            for (int n = 0; n < 4; n++)
                                if (s[n]) mreg[d][idx][8*n +: 8] = dv[8*n +: 8];
                        end
                    end else begin
                        exp_dat[d] = (idx < NREGS) ? mreg[d][idx] :
                                     (idx == NREGS) ? st : 32'h0;
                    end
                end
            end
            @(posedge clk); #1;
            exp_ack[d] = 1'b0; exp_err[d] = 1'b0;
            cyc[d] = 1'b0; stb[d] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            adr[d] = 32'h0; wdat[d] = 32'h0; bus_we[d] = 1'b0; sel[d] = 4'h0;
            stb[d] = 1'b0; cyc[d] = 1'b0; status[d] = 32'h0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_regs", regs_out[0], 128'h0);
        check("reset_ack", 128'(ack[0]), 128'h0);
        rst = 1'b0;

        // No wait states: full write, byte-lane write, status and register reads.
        xfer(0, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 32'h0, -1);
        check("write_deadbeef", 128'(regs_out[0][63:32]), 128'h0000_0000_DEAD_BEEF);
        xfer(0, 1'b1, BASE + 32'h4, 32'h1122_3344, 4'b0101, 32'h0, -1);
        check("byte_lanes", 128'(regs_out[0][63:32]), 128'h0000_0000_DE22_BE44);
        xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hCAFE_0001, -1);
        check("status_read", 128'(rd_dat[0]), 128'h0000_0000_CAFE_0001);
        xfer(0, 1'b0, BASE + 32'h4, 32'h0, 4'hF, 32'h0, -1);
        check("reg1_read", 128'(rd_dat[0]), 128'h0000_0000_DE22_BE44);
        xfer(0, 1'b1, BASE + 32'h3, 32'hA5A5_0F0F, 4'hF, 32'h0, -1);
        xfer(0, 1'b1, BASE + 32'hC, 32'h1234_5678, 4'b1000, 32'h0, -1);
        check("regs_after_writes", regs_out[0], 128'h12000000_00000000_DE22BE44_A5A50F0F);

        // Unmapped, status write, unmapped read, miss and sel==0: registers must not move.
        xfer(0, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, -1);
        xfer(0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, 32'h0, -1);
        xfer(0, 1'b0, BASE + 32'h3C, 32'h0, 4'hF, 32'h0, -1);
        xfer(0, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 32'h0, -1);
        xfer(0, 1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, 32'h0, -1);
        check("regs_unchanged", regs_out[0], 128'h12000000_00000000_DE22BE44_A5A50F0F);

        // Three wait states, then an aborted write that must leave reg2 alone.
        xfer(1, 1'b1, BASE + 32'h8, 32'h55AA_55AA, 4'hF, 32'h0, -1);
        xfer(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'h0, -1);
        check("wait_read", 128'(rd_dat[1]), 128'h0000_0000_55AA_55AA);
        xfer(1, 1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 32'h0, 2);
        check("abort_no_write", 128'(regs_out[1][95:64]), 128'h0000_0000_55AA_55AA);
        xfer(1, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'h0BAD_0003, -1);
        check("wait_status", 128'(rd_dat[1]), 128'h0000_0000_0BAD_0003);

        // Asynchronous reset in the middle of an ack cycle.
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; bus_we[0] = 1'b1;
        adr[0] = BASE; wdat[0] = 32'h0BAD_F00D; sel[0] = 4'hF;
        @(posedge clk); #1;
        exp_ack[0] = 1'b1;
        mreg[0][0] = 32'h0BAD_F00D;
        check("ack_before_reset", 128'(ack[0]), 128'h1);
        #2;
        rst = 1'b1;
        model_reset();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        #1;
        check("async_rst_ack", 128'(ack[0]), 128'h0);
        check("async_rst_regs0", regs_out[0], 128'h0);
        check("async_rst_regs1", regs_out[1], 128'h0);
        check("async_rst_dat", 128'(rd_dat[0]), 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        xfer(0, 1'b1, BASE + 32'h8, 32'h0000_00C3, 4'b0001, 32'h0, -1);
        check("post_reset_write", regs_out[0], 128'h00000000_000000C3_00000000_00000000);
        xfer(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'h0, -1);
        check("post_reset_read", 128'(rd_dat[1]), 128'h0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
